// File: rtl/ms_alarm_pkg.sv
// Shared definitions for the millisecond alarm scheduler: command opcodes,
// the default delay clamp and the wrap-safe deadline comparison.
package ms_alarm_pkg;

   typedef enum logic [1:0] {
      OP_NOP      = 2'b00,
      OP_ONESHOT  = 2'b01,
      OP_PERIODIC = 2'b10,
      OP_CANCEL   = 2'b11
   } alarm_op_e;

   // Largest delay whose deadline stays unambiguous under a signed 32-bit difference.
   localparam logic [31:0] MAX_DELAY_DEFAULT = 32'h7FFF_FFFF;

   // Deadline reached when (now - deadline) is non-negative as a signed 32-bit
   // value, which stays correct across the 2^32 wrap of the time base.
   function automatic logic is_due(input logic [31:0] now, input logic [31:0] deadline);
      logic [31:0] diff;
      diff = now - deadline;
      return ~diff[31];
   endfunction

endpackage

// File: rtl/ms_alarm_regfile.sv
// Per-channel alarm storage: deadline, period, periodic flag and armed flag.
// Two update sources (command and scan); a command to the same channel overrides
// the scan update. One read port addressed by the scan pointer.
module ms_alarm_regfile
   import ms_alarm_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int CH_W   = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_we,
   input  logic [CH_W-1:0]   cmd_ch,
   input  logic              cmd_arm,
   input  logic              cmd_periodic,
   input  logic [31:0]       cmd_deadline,
   input  logic [31:0]       cmd_period,
   input  logic              scan_we,
   input  logic [CH_W-1:0]   scan_ch,
   input  logic [31:0]       scan_deadline,
   input  logic              scan_active,
   input  logic [CH_W-1:0]   rd_ch,
   output logic [31:0]       rd_deadline,
   output logic [31:0]       rd_period,
   output logic              rd_periodic,
   output logic              rd_active,
   output logic [NUM_CH-1:0] active
);

   logic [31:0]       deadline_q [NUM_CH];
   logic [31:0]       period_q   [NUM_CH];
   logic [NUM_CH-1:0] periodic_q;
   logic [NUM_CH-1:0] active_q;

   // Timing fields carry no reset; they only matter while the channel is armed.
   // Scan update is written first so a same-channel command lands on top of it.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (scan_we && scan_ch == CH_W'(i)) begin
            deadline_q[i] <= scan_deadline;
         end
         if (cmd_we && cmd_arm && cmd_ch == CH_W'(i)) begin
            deadline_q[i] <= cmd_deadline;
            period_q[i]   <= cmd_period;
            periodic_q[i] <= cmd_periodic;
         end
      end
   end

   // Armed flags: scan may disarm a fired one-shot, command arms or cancels.
   always_ff @(posedge clk) begin
      if (reset) begin
         active_q <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (scan_we && scan_ch == CH_W'(i)) begin
               active_q[i] <= scan_active;
            end
            if (cmd_we && cmd_ch == CH_W'(i)) begin
               active_q[i] <= cmd_arm;
            end
         end
      end
   end

   // Read port for the channel currently under scan.
   always_comb begin
      rd_deadline = '0;
      rd_period   = '0;
      rd_periodic = 1'b0;
      rd_active   = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (rd_ch == CH_W'(i)) begin
            rd_deadline = deadline_q[i];
            rd_period   = period_q[i];
            rd_periodic = periodic_q[i];
            rd_active   = active_q[i];
         end
      end
   end

   assign active = active_q;

endmodule

// File: rtl/ms_alarm_scheduler.sv
// Software alarm scheduler sharing one free-running millisecond time base among
// NUM_CH channels. Channels are scanned round-robin, one per clock; a reached
// deadline sets a sticky pending flag that serves as the interrupt line.
module ms_alarm_scheduler
   import ms_alarm_pkg::*;
#(
   parameter int          NUM_CH    = 4,
   parameter int          CH_W      = 2,
   parameter logic [31:0] MAX_DELAY = MAX_DELAY_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       millis,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [CH_W-1:0]   cmd_ch,
   input  logic [31:0]       cmd_delay,
   input  logic [NUM_CH-1:0] irq_ack,
   output logic [NUM_CH-1:0] pending,
   output logic [NUM_CH-1:0] active
);

   alarm_op_e         op;
   logic              accept;
   logic [31:0]       delay_eff;
   logic              cmd_we;
   logic              cmd_arm;
   logic              cmd_periodic;
   logic [31:0]       cmd_deadline;
   logic [CH_W-1:0]   scan_ptr;
   logic [31:0]       rd_deadline;
   logic [31:0]       rd_period;
   logic              rd_periodic;
   logic              rd_active;
   logic              collide;
   logic              scan_fire;
   logic [31:0]       scan_deadline;
   logic [NUM_CH-1:0] fire_vec;

   assign op     = alarm_op_e'(cmd_op);
   assign accept = cmd_valid && cmd_ready;

   // Clamp the requested delay; a zero period would never advance, so it becomes 1.
   always_comb begin
      delay_eff = (cmd_delay > MAX_DELAY) ? MAX_DELAY : cmd_delay;
      if (op == OP_PERIODIC && delay_eff == 32'd0) begin
         delay_eff = 32'd1;
      end
   end

   assign cmd_we       = accept && (op != OP_NOP);
   assign cmd_arm      = (op != OP_CANCEL);
   assign cmd_periodic = (op == OP_PERIODIC);
   assign cmd_deadline = millis + delay_eff;

   // A command landing on the scanned channel discards that channel's scan result.
   assign collide   = cmd_we && (cmd_ch == scan_ptr);
   assign scan_fire = rd_active && is_due(millis, rd_deadline) && !collide;

   // Periodic deadlines advance from the old deadline, not from now, so they never drift.
   assign scan_deadline = rd_periodic ? (rd_deadline + rd_period) : rd_deadline;

   ms_alarm_regfile #(
      .NUM_CH (NUM_CH),
      .CH_W   (CH_W)
   ) u_regfile (
      .clk           (clk),
      .reset         (reset),
      .cmd_we        (cmd_we),
      .cmd_ch        (cmd_ch),
      .cmd_arm       (cmd_arm),
      .cmd_periodic  (cmd_periodic),
      .cmd_deadline  (cmd_deadline),
      .cmd_period    (delay_eff),
      .scan_we       (scan_fire),
      .scan_ch       (scan_ptr),
      .scan_deadline (scan_deadline),
      .scan_active   (rd_periodic),
      .rd_ch         (scan_ptr),
      .rd_deadline   (rd_deadline),
      .rd_period     (rd_period),
      .rd_periodic   (rd_periodic),
      .rd_active     (rd_active),
      .active        (active)
   );

   // Round-robin scan pointer, wrapping at NUM_CH-1 so non-power-of-two counts work.
   always_ff @(posedge clk) begin
      if (reset) begin
         scan_ptr <= '0;
      end else if (scan_ptr == CH_W'(NUM_CH - 1)) begin
         scan_ptr <= '0;
      end else begin
         scan_ptr <= scan_ptr + CH_W'(1);
      end
   end

   // One-hot of the channel firing this cycle.
   always_comb begin
      fire_vec = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (scan_fire && scan_ptr == CH_W'(i)) begin
            fire_vec[i] = 1'b1;
         end
      end
   end

   // Sticky pending flags; a firing set beats an acknowledge in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         pending <= '0;
      end else begin
         pending <= (pending & ~irq_ack) | fire_vec;
      end
   end

   // Ready dips for one cycle after every accept.
   always_ff @(posedge clk) begin
      if (reset) begin
         cmd_ready <= 1'b1;
      end else begin
         cmd_ready <= !accept;
      end
   end

endmodule

// File: tb/tb_ms_alarm_scheduler.sv
// Self-checking bench for ms_alarm_scheduler: directed scenarios followed by
// randomized traffic, every cycle compared against a behavioural model.
module tb_ms_alarm_scheduler;

   localparam int          NUM_CH = 4;
   localparam int          CH_W   = 2;
   localparam logic [31:0] MAX_D  = 32'h7FFF_FFFF;

   localparam logic [1:0] T_NOP = 2'd0, T_ONE = 2'd1, T_PER = 2'd2, T_CAN = 2'd3;

   logic              clk = 1'b0;
   logic              reset;
   logic [31:0]       millis;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd_op;
   logic [CH_W-1:0]   cmd_ch;
   logic [31:0]       cmd_delay;
   logic [NUM_CH-1:0] irq_ack;
   logic [NUM_CH-1:0] pending;
   logic [NUM_CH-1:0] active;

   always #5 clk = ~clk;

   ms_alarm_scheduler #(
      .NUM_CH    (NUM_CH),
      .CH_W      (CH_W),
      .MAX_DELAY (MAX_D)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .millis    (millis),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_ch    (cmd_ch),
      .cmd_delay (cmd_delay),
      .irq_ack   (irq_ack),
      .pending   (pending),
      .active    (active)
   );

   int checks = 0;
   int errors = 0;
   int millis_mode = 1;

   // Reference model state
   bit [31:0]       m_dl   [NUM_CH];
   bit [31:0]       m_per  [NUM_CH];
   bit              m_pmode[NUM_CH];
   bit [NUM_CH-1:0] m_act;
   bit [NUM_CH-1:0] m_pend;
   bit              m_ready;
   int              m_cyc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Apply one clock edge worth of the behavioural rules to the model.
   task automatic model_edge();
      int        p;
      bit        acc;
      bit        due;
      bit [31:0] dd;
      bit [31:0] diff;
      if (reset) begin
         m_act   = '0;
         m_pend  = '0;
         m_ready = 1'b1;
         m_cyc   = 0;
         return;
      end
      p    = m_cyc % NUM_CH;
      acc  = cmd_valid && m_ready;
      diff = millis - m_dl[p];
      due  = m_act[p] && ($signed(diff) >= 0);
      if (acc && cmd_op != T_NOP && int'(cmd_ch) == p) due = 1'b0;
      m_pend = m_pend & ~irq_ack;
      if (due) begin
         m_pend[p] = 1'b1;
         if (m_pmode[p]) m_dl[p] = m_dl[p] + m_per[p];
         else            m_act[p] = 1'b0;
      end
      if (acc) begin
         if (cmd_op == T_ONE || cmd_op == T_PER) begin
            dd = (cmd_delay > MAX_D) ? MAX_D : cmd_delay;
            if (cmd_op == T_PER && dd == 0) dd = 1;
            m_dl[cmd_ch]    = millis + dd;
            m_per[cmd_ch]   = dd;
            m_pmode[cmd_ch] = (cmd_op == T_PER);
            m_act[cmd_ch]   = 1'b1;
         end else if (cmd_op == T_CAN) begin
            m_act[cmd_ch] = 1'b0;
         end
      end
      m_ready = !acc;
      m_cyc++;
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      check("pending", pending, m_pend);
      check("active", active, m_act);
      check("cmd_ready", cmd_ready, m_ready);
      if (!reset) begin
         if (millis_mode == 1) millis = millis + 1;
         else                  millis = millis + ($urandom % 2);
      end
   endtask

   task automatic do_reset(input logic [31:0] start);
      reset     = 1'b1;
      millis    = start;
      cmd_valid = 1'b0;
      irq_ack   = '0;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic send(input logic [1:0] op, input int ch, input logic [31:0] delay);
      int guard;
      cmd_op    = op;
      cmd_ch    = CH_W'(ch);
      cmd_delay = delay;
      cmd_valid = 1'b1;
      guard     = 0;
      while (!m_ready && guard < 4) begin
         step();
         guard++;
      end
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_pend(input string tag, input int ch, input int budget);
      int n;
      n = 0;
      while (pending[ch] !== 1'b1 && n < budget) begin
         step();
         n++;
      end
      check(tag, pending[ch], 1'b1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [1:0]  b_op [3];
      int          b_ch [3];
      logic [31:0] b_dl [3];
      logic        rdy_obs;
      logic        acc;
      int          k;
      int          guard;

      for (int i = 0; i < NUM_CH; i++) begin
         m_dl[i] = 0; m_per[i] = 0; m_pmode[i] = 0;
      end
      reset = 1'b1; millis = 0; cmd_valid = 0; cmd_op = 0; cmd_ch = 0;
      cmd_delay = 0; irq_ack = 0;

      // Reset state and one-shot ch1, delay 5 at millis 100
      do_reset(32'd100);
      check("reset_pending", pending, 0);
      check("reset_active", active, 0);
      check("reset_ready", cmd_ready, 1);
      send(T_ONE, 1, 32'd5);
      check("os_active", active[1], 1);
      wait_pend("os_fire", 1, 20);
      check("os_latency", (millis - 1 >= 105) && (millis - 1 <= 108), 1);
      check("os_disarmed", active[1], 0);
      irq_ack = 4'b0010;
      step();
      irq_ack = 4'b0000;
      check("os_ack", pending[1], 0);

      // Periodic ch0, delay 3 at millis 10, then cancel
      do_reset(32'd10);
      send(T_PER, 0, 32'd3);
      for (int r = 0; r < 2; r++) begin
         wait_pend("per_fire", 0, 12);
         irq_ack = 4'b0001;
         step();
         irq_ack = 4'b0000;
      end
      send(T_CAN, 0, 32'd0);
      repeat (12) step();
      check("per_cancel_pend", pending[0], 0);
      check("per_cancel_act", active[0], 0);

      // Wrap across 2^32: deadline lands on 4
      do_reset(32'hFFFF_FFFA);
      send(T_ONE, 2, 32'd10);
      guard = 0;
      while (millis != 32'd4 && guard < 40) begin
         step();
         check("wrap_early", pending[2], 0);
         guard++;
      end
      wait_pend("wrap_fire", 2, 8);
      check("wrap_latency", (millis - 1 >= 4) && (millis - 1 <= 7), 1);

      // Clamp of an oversized delay, then zero delay
      do_reset(32'd1000);
      send(T_ONE, 3, 32'hFFFF_FFFF);
      repeat (20) step();
      check("clamp_no_fire", pending[3], 0);
      check("clamp_armed", active[3], 1);
      send(T_ONE, 3, 32'd0);
      wait_pend("zero_fire", 3, 5);

      // Back-to-back commands; the third cancels ch0 in its own scan slot while due
      do_reset(32'd0);
      b_op[0] = T_ONE; b_ch[0] = 0; b_dl[0] = 0;
      b_op[1] = T_PER; b_ch[1] = 1; b_dl[1] = 7;
      b_op[2] = T_CAN; b_ch[2] = 0; b_dl[2] = 0;
      k = 0;
      cmd_op = b_op[0]; cmd_ch = CH_W'(b_ch[0]); cmd_delay = b_dl[0];
      cmd_valid = 1'b1;
      for (int c = 0; c < 6; c++) begin
         rdy_obs = cmd_ready;
         check("b2b_ready", rdy_obs, (c % 2 == 0) ? 1 : 0);
         acc = cmd_valid && m_ready;
         step();
         if (acc) begin
            k++;
            if (k < 3) begin
               cmd_op = b_op[k]; cmd_ch = CH_W'(b_ch[k]); cmd_delay = b_dl[k];
            end else begin
               cmd_valid = 1'b0;
            end
         end
      end
      cmd_valid = 1'b0;
      repeat (8) step();
      check("collide_no_fire", pending[0], 0);
      check("collide_cancel", active[0], 0);

      // Set and acknowledge in the same cycle, then reset mid-periodic
      do_reset(32'd500);
      irq_ack = 4'b0010;
      send(T_ONE, 1, 32'd0);
      wait_pend("set_wins", 1, 8);
      step();
      check("ack_after_set", pending[1], 0);
      irq_ack = 4'b0000;
      send(T_PER, 2, 32'd1);
      repeat (10) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("midreset_pending", pending, 0);
      check("midreset_active", active, 0);

      // Randomized traffic
      millis_mode = 2;
      do_reset($urandom);
      for (int n = 0; n < 1500; n++) begin
         if ($urandom % 400 == 0) begin
            millis_mode = 2;
            do_reset($urandom);
         end
         cmd_valid = ($urandom % 2) == 1;
         cmd_op    = 2'($urandom % 4);
         cmd_ch    = CH_W'($urandom % NUM_CH);
         cmd_delay = ($urandom % 5 == 0) ? $urandom : ($urandom % 12);
         for (int i = 0; i < NUM_CH; i++) irq_ack[i] = ($urandom % 3) == 0;
         step();
      end
      cmd_valid = 1'b0;
      irq_ack   = '0;
      repeat (4) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
